// File: rtl/inv_lane_arbiter.sv
// Round-robin arbiter that shares one registered bitwise-inverter lane between NUM_REQ requesters.
// Each grant lasts at most BURST_MAX words. Every release is followed by one idle cycle before the next grant.
module inv_lane_arbiter #(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned BURST_MAX = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_n;
  logic [ID_W-1:0]     owner, owner_n;
  logic [ID_W-1:0]     ptr, ptr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NUM_REQ-1:0]  gnt_n;
  logic                out_valid_n;
  logic [DATA_W-1:0]   out_data_n;
  logic [ID_W-1:0]     out_id_n;
  logic [DATA_W-1:0]   owner_word;
  logic [ID_W-1:0]     pick;
  logic                accept;

  // First set request at or above p, wrapping back to index 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] cand;
    logic            found;
    int unsigned     idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  always_comb begin
    owner_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) owner_word = data_in[i*DATA_W +: DATA_W];
    end
  end

  assign pick   = rr_pick(req, ptr);
  assign accept = (state == GRANT) && req[owner];

  // Next-state, pointer/burst bookkeeping and lane outputs
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    ptr_n       = ptr;
    cnt_n       = cnt;
    gnt_n       = gnt;
    out_valid_n = 1'b0;
    out_data_n  = out_data;
    out_id_n    = out_id;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (|req) begin
          state_n = GRANT;
          owner_n = pick;
          gnt_n   = NUM_REQ'(1) << pick;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          out_valid_n = 1'b1;
          out_data_n  = ~owner_word;
          out_id_n    = owner;
          cnt_n       = cnt + CNT_W'(1);
        end
        // Release on a dropped request or on the last word of the burst
        if (!accept || cnt == CNT_W'(BURST_MAX - 1)) begin
          state_n = IDLE;
          gnt_n   = '0;
          cnt_n   = '0;
          ptr_n   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      busy      <= (state_n == GRANT);
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_id    <= out_id_n;
    end
  end

endmodule

// File: tb/tb_inv_lane_arbiter.sv
// Randomized and directed bench for inv_lane_arbiter. An abstract grant/burst model feeds a result
// scoreboard, and a negedge monitor compares the DUT against it.
module tb_inv_lane_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned ID_W      = 2;

  typedef struct {
    int          id;
    logic [7:0]  data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model state
  bit          started     = 1'b0;
  bit          m_busy      = 1'b0;
  int          m_owner     = 0;
  int          m_words     = 0;
  int          m_next_from = 0;
  bit          m_after_rst = 1'b0;
  logic [3:0]  m_gnt       = '0;

  inv_lane_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .busy     (busy),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the lane, how many words it has sent, where the next search starts
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_busy      = 1'b0;
      m_owner     = 0;
      m_words     = 0;
      m_next_from = 0;
      m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int c;
          c = (m_next_from + k) % NUM_REQ;
          if (!m_busy && req[c]) begin
            m_busy  = 1'b1;
            m_owner = c;
            m_words = 0;
          end
        end
      end else if (req[m_owner]) begin
        exp_t e;
        e.id   = m_owner;
        e.data = ~data_in[m_owner*DATA_W +: DATA_W];
        exp_q.push_back(e);
        m_words++;
        if (m_words == BURST_MAX) begin
          m_busy      = 1'b0;
          m_next_from = (m_owner + 1) % NUM_REQ;
        end
      end else begin
        m_busy      = 1'b0;
        m_next_from = (m_owner + 1) % NUM_REQ;
      end
    end
    m_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
  end

  // Monitor: the results and the grant are sampled half a cycle after the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_after_rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_id", 32'(out_id), 32'(e.id));
        end
      end else begin
        chk("missing_out_valid", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
  end

  task automatic step(input logic r_rst, input logic [3:0] r, input logic [31:0] d);
    @(negedge clk);
    rst     = r_rst;
    req     = r;
    data_in = d;
  endtask

  initial begin
    logic [7:0] stream [5];
    stream[0] = 8'h00; stream[1] = 8'h5A; stream[2] = 8'hFF;
    stream[3] = 8'h0F; stream[4] = 8'h33;

    rst = 1'b1; req = 4'b1111; data_in = 32'h11223344;
    step(1'b1, 4'b1111, 32'h11223344);
    step(1'b0, 4'b1111, 32'h55667788);
    repeat (4) step(1'b0, 4'b1111, $urandom);

    // Single requester, forced rotation and re-grant
    step(1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0100, {8'h00, stream[i % 5], 16'h0000});

    // All requesting: rotation 0,1,2,3,0
    step(1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 26; i++) step(1'b0, 4'b1111, $urandom);

    // Early release by owner 1 after two words
    step(1'b1, 4'b0000, 32'h0);
    step(1'b0, 4'b0010, 32'h0);
    step(1'b0, 4'b1111, 32'h0000C300);
    step(1'b0, 4'b1111, 32'h00003C00);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1101, $urandom);

    // Reset on the 3rd word of owner 0, then owner 0 wins over 3 while 3 toggles
    step(1'b1, 4'b0000, 32'h0);
    step(1'b0, 4'b0001, 32'h0);
    step(1'b0, 4'b1001, 32'hAA000001);
    step(1'b0, 4'b1001, 32'hBB000002);
    step(1'b1, 4'b1001, 32'hCC000003);
    for (int i = 0; i < 8; i++)
      step(1'b0, {i[0], 3'b001}, {8'($urandom), 16'h0, 8'(i)});

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), 4'($urandom), $urandom);

    step(1'b0, 4'b0000, 32'h0);
    repeat (4) step(1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
